// File: rtl/mips_led_ctrl_if.sv
// CPU data-bus port of the LED controller: write strobe, register select,
// write data and combinational read data.
interface mips_led_ctrl_if;
  // Single-cycle bus, no valid/ready: a write is taken on every rising edge
  // where we=1; rdata always reflects addr combinationally, with no wait states.
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/mips_led_ctrl.sv
// Memory-mapped N_LED channel controller: static, blink, PWM or inverted per channel.
// Optional PWM hardware (DUTY register, pwm_cnt) is built only when LED_PWM_EN is defined.
module mips_led_ctrl #(
  parameter int N_LED = 8,
  parameter int PRE_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  mips_led_ctrl_if.slave   bus,
  output logic [N_LED-1:0] led
);
  logic [N_LED-1:0]   data_r;
  logic [2*N_LED-1:0] mode_r;
  logic [PRE_W-1:0]   prescale_r;
  logic [PRE_W-1:0]   pre_cnt;
  logic               blink_ph;
  logic               pwm_on;
  logic [N_LED-1:0]   f;
  logic               wr_data;
  logic               wr_mode;
  logic               wr_pre;
  logic               unused_wdata;

  assign wr_data = bus.we && (bus.addr == 2'd0);
  assign wr_mode = bus.we && (bus.addr == 2'd1);
  assign wr_pre  = bus.we && (bus.addr == 2'd2);
  assign unused_wdata = ^bus.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_r     <= '0;
      mode_r     <= '0;
      prescale_r <= '0;
    end else begin
      if (wr_data) data_r     <= bus.wdata[N_LED-1:0];
      if (wr_mode) mode_r     <= bus.wdata[2*N_LED-1:0];
      if (wr_pre)  prescale_r <= bus.wdata[PRE_W-1:0];
    end
  end

  // A PRESCALE write restarts the count so a lowered limit never wraps around.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt  <= '0;
      blink_ph <= 1'b0;
    end else if (wr_pre) begin
      pre_cnt  <= '0;
    end else if (pre_cnt == prescale_r) begin
      pre_cnt  <= '0;
      blink_ph <= ~blink_ph;
    end else begin
      pre_cnt  <= pre_cnt + 1'b1;
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] duty_r;
  logic [7:0] pwm_cnt;
  logic       wr_duty;

  assign wr_duty = bus.we && (bus.addr == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_r  <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr_duty) duty_r <= bus.wdata[7:0];
    end
  end

  assign pwm_on = (pwm_cnt < duty_r);
`else
  // Without PWM hardware, mode 10 collapses to a plain static channel.
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    f = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode_r[2*i +: 2])
        2'b00:   f[i] = data_r[i];
        2'b01:   f[i] = data_r[i] & blink_ph;
        2'b10:   f[i] = data_r[i] & pwm_on;
        default: f[i] = ~data_r[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) led <= '0;
    else       led <= f;
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0: bus.rdata[N_LED-1:0]   = data_r;
      2'd1: bus.rdata[2*N_LED-1:0] = mode_r;
      2'd2: bus.rdata[PRE_W-1:0]   = prescale_r;
      default: begin
`ifdef LED_PWM_EN
        bus.rdata[7:0] = duty_r;
`endif
      end
    endcase
  end
endmodule

// File: tb/tb_mips_led_ctrl.sv
// Bench for mips_led_ctrl: directed steps then random bus traffic, checked
// against an arithmetic model of registers, blink phase and PWM position.
module tb_mips_led_ctrl;
  localparam int N  = 8;
  localparam int PW = 24;

  logic         clk;
  logic         reset;
  logic [N-1:0] led;
  mips_led_ctrl_if bus ();

  mips_led_ctrl #(.N_LED(N), .PRE_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .led   (led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_q[$];
  bit model_valid = 0;

  // Reference model: blink phase = phase at last anchor (reset or PRESCALE
  // write) xor parity of completed half-periods since; PWM position = edges
  // since reset mod 256.
  logic [N-1:0]      m_data;
  logic [2*N-1:0]    m_mode;
  longint unsigned   m_pre;
  longint unsigned   m_n;
  longint unsigned   m_pwm_n;
  int unsigned       m_duty;
  bit                m_ph0;

  function automatic bit model_ph();
    return m_ph0 ^ (((m_n / (m_pre + 1)) % 2) != 0);
  endfunction

  function automatic logic [N-1:0] model_led();
    logic [N-1:0] r;
    bit pw;
`ifdef LED_PWM_EN
    pw = (m_pwm_n % 256) < m_duty;
`else
    pw = 1'b1;
`endif
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (m_mode[2*i +: 2])
        2'b00:   r[i] = m_data[i];
        2'b01:   r[i] = m_data[i] & model_ph();
        2'b10:   r[i] = m_data[i] & pw;
        default: r[i] = ~m_data[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[N-1:0]   = m_data;
      2'd1: r[2*N-1:0] = m_mode;
      2'd2: r[PW-1:0]  = m_pre[PW-1:0];
      default: begin
`ifdef LED_PWM_EN
        r = 32'(m_duty);
`endif
      end
    endcase
    return r;
  endfunction

  task automatic model_edge(input logic rst, input logic w, input logic [1:0] a,
                            input logic [31:0] d);
    if (rst) begin
      m_data = '0; m_mode = '0; m_pre = 0; m_duty = 0;
      m_n = 0; m_ph0 = 0; m_pwm_n = 0;
    end else begin
      m_pwm_n++;
      if (w && a == 2'd2) begin
        m_ph0 = model_ph();
        m_pre = longint'(d[PW-1:0]);
        m_n   = 0;
      end else begin
        m_n++;
      end
      if (w) begin
        case (a)
          2'd0: m_data = d[N-1:0];
          2'd1: m_mode = d[2*N-1:0];
          2'd3: begin
`ifdef LED_PWM_EN
            m_duty = d[7:0];
`endif
          end
          default: ;
        endcase
      end
    end
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: one full clock with read check before the edge, led check after
  task automatic cycle(input logic rst, input logic w, input logic [1:0] a,
                       input logic [31:0] d);
    logic [N-1:0] e;
    reset = rst; bus.we = w; bus.addr = a; bus.wdata = d;
    #1;
    if (model_valid) check("rdata", bus.rdata, model_read(a));
    exp_q.push_back(rst ? '0 : model_led());
    @(posedge clk);
    model_edge(rst, w, a, d);
    #1;
    e = exp_q.pop_front();
    if (model_valid) check("led", 32'(led), 32'(e));
    model_valid = 1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
  endtask

  initial begin
    int first;
    int hi;
    logic p0;
    reset = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    @(negedge clk);

    // 1: reset held 5 cycles, then everything reads 0
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 2'(i), 32'hFFFF_FFFF);
    for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 2'(a), 32'h0);
    check("led_after_reset", 32'(led), 32'h0);

    // 2: static DATA, 2-cycle latency, old value read during write
    wr(2'd0, 32'hFFFF_FFA5);
    check("led_one_edge_after_write", 32'(led), 32'h0);
    cycle(1'b0, 1'b0, 2'd0, 32'h0);
    check("led_static_a5", 32'(led), 32'hA5);
    check("rd_data", bus.rdata, 32'h0000_00A5);

    // 3: channel 0 blinks with half-period 4
    wr(2'd1, 32'h0001);
    wr(2'd2, 32'd3);
    idle(24);

    // 4: PRESCALE=9 written mid-count -> first phase change 10 edges later
    idle(2);
    wr(2'd2, 32'd9);
    p0 = led[0];
    first = 0;
    for (int j = 1; j <= 14; j++) begin
      idle(1);
      if (first == 0 && led[0] != p0) first = j;
    end
    check("first_toggle_after_prescale", 32'(first), 32'd11);
    check("led_static_others", 32'(led[7:1]), 32'(7'b1010010));

    // lowering PRESCALE below a running count
    wr(2'd2, 32'd200);
    idle(40);
    wr(2'd2, 32'd2);
    idle(12);
    wr(2'd2, 32'd0);
    idle(6);

    // 5: PWM channel 0
    wr(2'd0, 32'h01);
    wr(2'd1, 32'h0002);
    wr(2'd3, 32'd64);
    idle(2);
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      idle(1);
      hi += int'(led[0]);
    end
`ifdef LED_PWM_EN
    check("pwm_duty64_high", 32'(hi), 32'd64);
`else
    check("mode10_static_high", 32'(hi), 32'd256);
    check("duty_reads_zero", model_read(2'd3), 32'h0);
`endif
    wr(2'd3, 32'd0);
    idle(2);
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      idle(1);
      hi += int'(led[0]);
    end
`ifdef LED_PWM_EN
    check("pwm_duty0_high", 32'(hi), 32'd0);
`else
    check("mode10_static_high2", 32'(hi), 32'd256);
`endif

    // 6: inverted static, then reset during blinking
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'hFFFF);
    idle(1);
    check("inv_data_ff", 32'(led), 32'h00);
    wr(2'd0, 32'h00);
    idle(1);
    check("inv_data_00", 32'(led), 32'hFF);
    wr(2'd0, 32'hFF);
    wr(2'd1, 32'h5555);
    wr(2'd2, 32'd1);
    idle(7);
    cycle(1'b1, 1'b1, 2'd0, 32'hFF);
    check("led_after_mid_reset", 32'(led), 32'h0);
    for (int a = 0; a < 4; a++) cycle(1'b0, 1'b0, 2'(a), 32'h0);

    // random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd2 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 7);
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, a, d);
    end

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
